// File: rtl/uart_tx_fifo_if.sv
// Push-side handshake bundle for uart_tx_fifo: the source drives a word and valid,
// the transmitter answers with ready.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter fed by a small FIFO; frames are sent back-to-back
// with configurable bit time, data width, parity and stop bits.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset_pin,
    uart_tx_fifo_if.slave                 s_in,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [PW:0]   FULL_COUNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [PW:0]          r_count;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [DATA_BITS-1:0] w_head;
    logic                 r_parity;
    logic                 w_parity_next;
    logic [CW-1:0]        r_baud;
    logic [3:0]           r_bit;
    logic                 r_tx;
    logic                 w_tx_next;
    logic                 w_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_baud_done;

    assign w_ready        = (r_count < FULL_COUNT) && reset_pin;
    assign s_in.in_ready  = w_ready;
    assign w_push         = s_in.in_valid && w_ready;
    assign w_head         = r_mem[r_rd_ptr];
    assign w_baud_done    = (r_baud == BAUD_LAST);

    assign tx         = r_tx;
    assign busy       = (r_state != IDLE) || (r_count != '0);
    assign fifo_count = r_count;

    always_comb begin
        w_state_next  = r_state;
        w_pop         = 1'b0;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_tx_next     = 1'b1;
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_baud_done) w_state_next = DATA;
            end
            DATA: begin
                if (w_baud_done) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit == DATA_LAST) w_state_next = (PARITY != 0) ? PAR : STOP;
                end
            end
            PAR: begin
                if (w_baud_done) w_state_next = STOP;
            end
            STOP: begin
                // Popping on the last stop cycle chains the next start bit with no idle gap
                if (w_baud_done && (r_bit == STOP_LAST)) begin
                    if (r_count != '0) begin
                        w_pop        = 1'b1;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        if (w_pop) begin
            w_shift_next  = w_head;
            w_parity_next = (PARITY == 1) ? ~(^w_head) : (^w_head);
        end

        // tx is registered, so it is derived from where the FSM will be after this edge
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            PAR:     w_tx_next = w_parity_next;
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= s_in.in_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_pin) begin
            r_state  <= IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_baud   <= '0;
            r_bit    <= '0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_state_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_tx     <= w_tx_next;
            r_baud   <= ((r_state == IDLE) || w_baud_done) ? '0 : r_baud + CW'(1);
            if (w_state_next != r_state) r_bit <= '0;
            else if (w_baud_done)        r_bit <= r_bit + 4'd1;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1 depth 4, 8E1, 7O2) share a frame
// monitor that checks every tx cycle against a scoreboard of modelled frames.
module tb_uart_tx_fifo;
    localparam int CPB = 4;

    typedef struct {
        logic [15:0] bits;
        int          len;
    } frame_t;

    typedef struct {
        int         sel;
        logic [8:0] data;
        int         len;
        int         par;
    } vec_t;

    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    logic tx0, tx1, tx2;
    logic busy0, busy1, busy2;
    logic [2:0] cnt0;
    logic [4:0] cnt1, cnt2;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_BITS(8)) if0 ();
    uart_tx_fifo_if #(.DATA_BITS(8)) if1 ();
    uart_tx_fifo_if #(.DATA_BITS(7)) if2 ();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .reset_pin(rst0), .s_in(if0), .tx(tx0), .busy(busy0), .fifo_count(cnt0));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
        .clk(clk), .reset_pin(rst1), .s_in(if1), .tx(tx1), .busy(busy1), .fifo_count(cnt1));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16)) u2 (
        .clk(clk), .reset_pin(rst2), .s_in(if2), .tx(tx2), .busy(busy2), .fifo_count(cnt2));

    int          nCompared = 0;
    int          nMismatched = 0;
    int          sel = 0;
    int          nc = 0;
    logic        monEn = 1'b0;
    logic        inFrame = 1'b0;
    int          k = 0;
    frame_t      cur;
    frame_t      expQ[$];
    int          startLog[$];
    logic [15:0] actBits = '1;
    logic [15:0] lastBits = '1;
    vec_t        vecs[11];

    function logic curTx();
        case (sel)
            0:       return tx0;
            1:       return tx1;
            default: return tx2;
        endcase
    endfunction

    function logic curBusy();
        case (sel)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function logic curReady();
        case (sel)
            0:       return if0.in_ready;
            1:       return if1.in_ready;
            default: return if2.in_ready;
        endcase
    endfunction

    function int curCount();
        case (sel)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    function int cfgBits(input int s);
        return (s == 2) ? 7 : 8;
    endfunction

    function int cfgPar(input int s);
        return (s == 1) ? 2 : ((s == 2) ? 1 : 0);
    endfunction

    function int cfgStops(input int s);
        return (s == 2) ? 2 : 1;
    endfunction

    function int lastStart();
        return (startLog.size() > 0) ? startLog[$] : -100000;
    endfunction

    // Reference frame: start, LSB-first data, optional parity, stop bits
    function frame_t modelFrame(input logic [8:0] d, input int s);
        frame_t f;
        int     idx;
        logic   p;
        f.bits = '0;
        idx = 1;
        p = 1'b0;
        for (int i = 0; i < cfgBits(s); i++) begin
            f.bits[idx] = d[i];
            p = p ^ d[i];
            idx++;
        end
        if (cfgPar(s) != 0) begin
            f.bits[idx] = (cfgPar(s) == 1) ? ~p : p;
            idx++;
        end
        for (int i = 0; i < cfgStops(s); i++) begin
            f.bits[idx] = 1'b1;
            idx++;
        end
        f.len = idx;
        return f;
    endfunction

    task automatic checkOutput(input string name, input int act, input int req);
        nCompared++;
        if (act !== req) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic setIn(input logic v, input logic [8:0] d);
        case (sel)
            0: begin if0.in_valid = v; if0.in_data = d[7:0]; end
            1: begin if1.in_valid = v; if1.in_data = d[7:0]; end
            default: begin if2.in_valid = v; if2.in_data = d[6:0]; end
        endcase
    endtask

    // Offers a word at a negedge, holds it until accepted, returns at the negedge after the accept edge
    task automatic applyStimulus(input logic [8:0] d, output int accNc);
        accNc = -1;
        setIn(1'b1, d);
        for (int t = 0; t < 200; t++) begin
            if (curReady()) begin
                accNc = nc;
                expQ.push_back(modelFrame(d, sel));
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        checkOutput("acceptTimeout", int'(curReady()), 1);
    endtask

    task automatic waitIdle(input int bound, output int endNc);
        endNc = -1;
        for (int t = 0; t < bound; t++) begin
            @(negedge clk);
            if (!curBusy() && !inFrame && expQ.size() == 0) begin
                endNc = nc;
                return;
            end
        end
        checkOutput("idleTimeout", int'(curBusy()), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            nc++;
        end
    end

    // Frame monitor: a falling tx line starts a frame, then every cycle is checked against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!monEn) begin
                inFrame = 1'b0;
            end else begin
                if (!inFrame && curTx() == 1'b0) begin
                    if (expQ.size() == 0) begin
                        checkOutput("startWithoutWord", int'(curTx()), 1);
                    end else begin
                        cur = expQ.pop_front();
                        inFrame = 1'b1;
                        k = 0;
                        actBits = '1;
                        startLog.push_back(nc);
                    end
                end
                if (inFrame) begin
                    checkOutput("txBit", int'(curTx()), int'(cur.bits[k / CPB]));
                    if (k % CPB == 0) actBits[k / CPB] = curTx();
                    k++;
                    if (k == cur.len * CPB) begin
                        inFrame = 1'b0;
                        lastBits = actBits;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         a, e, n0, lows;
        int         acc[6];
        logic [8:0] bbw[3];
        logic [8:0] fw[6];

        vecs[0]  = '{0, 9'h000, 10, -1};
        vecs[1]  = '{0, 9'h0FF, 10, -1};
        vecs[2]  = '{0, 9'h03C, 10, -1};
        vecs[3]  = '{1, 9'h007, 11, 1};
        vecs[4]  = '{1, 9'h000, 11, 0};
        vecs[5]  = '{1, 9'h080, 11, 1};
        vecs[6]  = '{1, 9'h0FF, 11, 0};
        vecs[7]  = '{2, 9'h041, 11, 1};
        vecs[8]  = '{2, 9'h07F, 11, 0};
        vecs[9]  = '{2, 9'h000, 11, 1};
        vecs[10] = '{2, 9'h02A, 11, 0};
        bbw = '{9'h011, 9'h0C3, 9'h07E};
        fw  = '{9'h001, 9'h002, 9'h0F0, 9'h055, 9'h0AA, 9'h099};

        if0.in_valid = 1'b0; if0.in_data = '0;
        if1.in_valid = 1'b0; if1.in_data = '0;
        if2.in_valid = 1'b0; if2.in_data = '0;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        checkOutput("rstReady0", int'(if0.in_ready), 0);
        checkOutput("rstReady1", int'(if1.in_ready), 0);
        checkOutput("rstReady2", int'(if2.in_ready), 0);
        checkOutput("rstTx0", int'(tx0), 1);
        checkOutput("rstTx2", int'(tx2), 1);
        checkOutput("rstBusy0", int'(busy0), 0);
        checkOutput("rstBusy1", int'(busy1), 0);
        checkOutput("rstCount0", int'(cnt0), 0);
        checkOutput("rstCount2", int'(cnt2), 0);
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        @(negedge clk);
        checkOutput("postRstReady0", int'(if0.in_ready), 1);
        checkOutput("postRstReady1", int'(if1.in_ready), 1);
        checkOutput("postRstTx1", int'(tx1), 1);
        monEn = 1'b1;

        $display("[TB] 8N1 single word 0xA5");
        sel = 0;
        n0 = startLog.size();
        applyStimulus(9'h0A5, a);
        setIn(1'b0, 9'h000);
        checkOutput("a5CountAfterAccept", curCount(), 1);
        checkOutput("a5BusyAfterAccept", int'(curBusy()), 1);
        checkOutput("a5TxBeforePop", int'(curTx()), 1);
        @(negedge clk);
        checkOutput("a5TxFalls", int'(curTx()), 0);
        waitIdle(500, e);
        checkOutput("a5Frames", startLog.size() - n0, 1);
        checkOutput("a5StartLatency", lastStart() - a, 2);
        checkOutput("a5Duration", e - lastStart(), 40);
        checkOutput("a5Bits", int'(lastBits[9:0]), 'h34A);
        checkOutput("a5CountEnd", curCount(), 0);

        $display("[TB] frame format table");
        for (int i = 0; i < 11; i++) begin
            sel = vecs[i].sel;
            applyStimulus(vecs[i].data, a);
            setIn(1'b0, 9'h000);
            waitIdle(1000, e);
            checkOutput("vecLen", e - lastStart(), vecs[i].len * CPB);
            if (vecs[i].par >= 0)
                checkOutput("vecParity", int'(lastBits[1 + cfgBits(sel)]), vecs[i].par);
            checkOutput("vecStop", int'(lastBits[vecs[i].len - 1]), 1);
            checkOutput("vecStopFirst", int'(lastBits[2 + cfgBits(sel) - ((sel == 0) ? 1 : 0)]), 1);
        end

        $display("[TB] back-to-back");
        sel = 0;
        n0 = startLog.size();
        for (int i = 0; i < 3; i++) applyStimulus(bbw[i], acc[i]);
        setIn(1'b0, 9'h000);
        waitIdle(1000, e);
        checkOutput("b2bFrames", startLog.size() - n0, 3);
        if (startLog.size() - n0 == 3) begin
            checkOutput("b2bGap1", startLog[n0 + 1] - startLog[n0], 40);
            checkOutput("b2bGap2", startLog[n0 + 2] - startLog[n0 + 1], 40);
            checkOutput("b2bTotal", e - startLog[n0], 120);
        end

        $display("[TB] FIFO full");
        n0 = startLog.size();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                checkOutput("fullCount", curCount(), 4);
                checkOutput("fullReady", int'(curReady()), 0);
            end
            applyStimulus(fw[i], acc[i]);
        end
        setIn(1'b0, 9'h000);
        checkOutput("fullAccept5", acc[4] - acc[0], 4);
        checkOutput("fullAccept6", acc[5] - acc[0], 42);
        waitIdle(2000, e);
        checkOutput("fullFrames", startLog.size() - n0, 6);

        $display("[TB] reset mid-frame");
        n0 = startLog.size();
        for (int i = 0; i < 3; i++) applyStimulus(bbw[i], acc[i]);
        setIn(1'b0, 9'h000);
        for (int t = 0; t < 20 && startLog.size() == n0; t++) @(negedge clk);
        checkOutput("midStarted", startLog.size() - n0, 1);
        repeat (3 * CPB) @(negedge clk);
        monEn = 1'b0;
        rst0 = 1'b0;
        @(negedge clk);
        checkOutput("midRstTx", int'(tx0), 1);
        checkOutput("midRstCount", int'(cnt0), 0);
        checkOutput("midRstBusy", int'(busy0), 0);
        checkOutput("midRstReady", int'(if0.in_ready), 0);
        rst0 = 1'b1;
        expQ.delete();
        lows = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            monEn = 1'b1;
            if (tx0 == 1'b0) lows++;
        end
        checkOutput("midQuietLows", lows, 0);
        checkOutput("midQuietBusy", int'(busy0), 0);
        applyStimulus(9'h05A, a);
        setIn(1'b0, 9'h000);
        waitIdle(500, e);
        checkOutput("midResumeLen", e - lastStart(), 40);
        checkOutput("midResumeLatency", lastStart() - a, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
